dac_dma_rd_ring_ctrl: RTL and testbench
=======================================

Name: dac_dma_rd_ring_ctrl

Overview:
- Next-generation DAC DMA read sequencer. Replaces fixed two-buffer ping-pong with an N-block ring of DDR buffers (run-time block count, parametrised stride).
- Adds bounded loop count, run status and done pulse.
- Sits between the PCIe/host register file (cfg_*/sts_*) and the AXI DMA read engine (cfg_rstart/cfg_raddr/cfg_rlen/cfg_ridle). Issues one DMA read per block and advances on each DMA-idle rising edge.

Parameters:
- LEN_WDTH, 32, width of block length and counters
- ADDR_WDTH, 32, AXI address width
- BLK_NUM, 4, maximum ring blocks (power of two, 2..16)
- BLK_IDX_WDTH, $clog2(BLK_NUM), block index width (derived, do not override)
- AXI_BASE_ADDR, 32'h9000_0000, address of block 0
- BLK_STRIDE, 32'h1000_0000, address offset between consecutive blocks
- TIMEOUT_CYC, 32'd50_000_000, watchdog limit (used only with the optional feature)

Ports:
- sys_clk  in  1  single clock
- sys_rst  in  1  synchronous, active-high reset
- cfg_rs  in  1  run request, async level; a rising edge starts a run
- cfg_mode  in  1  0 = single pass, 1 = loop
- cfg_rst  in  1  synchronous soft clear/abort
- cfg_size  in  LEN_WDTH  bytes per block; latched at run start
- cfg_blk_cnt  in  BLK_IDX_WDTH+1  active blocks per pass; latched at run start
- cfg_loop_num  in  LEN_WDTH  passes in loop mode, 0 = infinite; latched at run start
- sts_blk_idx  out  BLK_IDX_WDTH  index of block currently addressed
- sts_rec_times  out  LEN_WDTH  completed full passes
- sts_busy  out  1  run in progress
- sts_done  out  1  one-cycle pulse when a run ends normally
- sts_timeout  out  1  sticky watchdog flag
- cfg_rsoft_rst  out  1  soft reset to DMA engine
- cfg_rstart  out  1  one-cycle DMA start pulse
- cfg_raddr  out  ADDR_WDTH  DMA read address
- cfg_rlen  out  LEN_WDTH  DMA read length
- cfg_ridle  in  1  DMA idle, async level

Behaviour:
- Synchronisation: cfg_rs and cfg_ridle each pass through a 2-flop synchroniser, then a rising-edge detect (registered). If cfg_rs is first sampled high at edge T, run_trig is asserted at T+3.
- Reset (sys_rst, or cfg_rst with lower priority) forces the following. cfg_rst also aborts a run in progress immediately, with no sts_done.
  - State: IDLE.
  - Outputs cleared: sts_blk_idx, sts_rec_times, sts_busy, sts_done, cfg_rstart.
  - Latched config cleared: size, blk_cnt, loop_num.
  - Pass counter cleared.
  - sts_timeout cleared.
  - cfg_raddr = AXI_BASE_ADDR; cfg_rlen = 0.
- cfg_rsoft_rst = cfg_rst OR the timeout pulse (combinational OR of registered sources).
- State machine:
  - IDLE:
    - On run_trig with cfg_size != 0: latch config. cfg_blk_cnt of 0 is treated as 1; values above BLK_NUM are clamped to BLK_NUM.
    - Set idx = 0 and go to START.
    - run_trig with cfg_size == 0 is ignored.
  - START: cfg_rstart = 1 for exactly this cycle, then go to WAIT. cfg_rstart is asserted at T+4 relative to the cfg_rs sample edge.
  - WAIT: on the synchronised cfg_ridle rising edge, go to NEXT. Edges seen in IDLE or START are ignored.
  - NEXT (one cycle):
    - If idx < blk_cnt-1: idx++, go to START.
    - Otherwise the pass is complete: sts_rec_times++ (saturates at all ones).
      - Loop mode, and (loop_num == 0 or passes < loop_num): idx = 0, go to START.
      - Otherwise: pulse sts_done and go to IDLE.
- cfg_raddr = AXI_BASE_ADDR + idx*BLK_STRIDE, truncated modulo 2^ADDR_WDTH. Registered; stable from START until the next idx change.
- cfg_rlen = latched size.
- sts_busy = (state != IDLE).
- cfg_rs edges while busy are ignored. A held-high cfg_rs does not retrigger.
- cfg_mode changes mid-run have no effect (value latched at start).

Optional Feature:
- Macro DAC_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while in WAIT.
  - If it reaches TIMEOUT_CYC without a cfg_ridle edge:
    - set sts_timeout (sticky until reset or cfg_rst);
    - pulse cfg_rsoft_rst for 1 cycle;
    - go to IDLE with no sts_done.
- Undefined: no counter; sts_timeout is tied to 0; the port is still present.

Decomposition:
- Package dac_dma_pkg holds:
  - state encoding localparams: IDLE, START, WAIT, NEXT (one-hot, 4 bits);
  - default base address and stride constants.
- One sub-module: cmip_edge_sync_sr. It is the 2-flop synchroniser plus rising-edge detect with synchronous active-high reset, instantiated twice.

Test Plan:
- BLK_NUM=4, cfg_blk_cnt=3, cfg_mode=0, cfg_size=0x1000; raise cfg_rs; ack each start with a cfg_ridle low-then-high. Expect:
  - three cfg_rstart pulses at addresses 0x9000_0000, 0xA000_0000, 0xB000_0000, cfg_rlen=0x1000;
  - first pulse exactly 4 cycles after cfg_rs sampled high;
  - sts_rec_times=1, one sts_done, sts_busy low after.
- Loop mode, cfg_loop_num=2, cfg_blk_cnt=2 -> 4 starts; sts_rec_times=2; sts_done once.
- Loop mode, cfg_loop_num=0, 5 passes, then cfg_rst in WAIT -> IDLE next cycle; sts_rec_times=0; cfg_rsoft_rst high with cfg_rst; no sts_done.
- Edge cases:
  - cfg_size=0 -> no cfg_rstart;
  - cfg_blk_cnt=0 -> single block at base address;
  - cfg_blk_cnt=7 -> clamped to 4 blocks;
  - second cfg_rs edge mid-run -> ignored.
- With DAC_RD_TIMEOUT_EN and TIMEOUT_CYC=100, cfg_ridle never toggles -> sts_timeout=1 after 100 WAIT cycles; 1-cycle cfg_rsoft_rst; state IDLE.

Source files
------------

// File: rtl/dac_dma_pkg.sv
// rtl/dac_dma_pkg.sv - State encoding and default address map for the DAC DMA ring reader.
package dac_dma_pkg;

  localparam int ST_WDTH = 4;

  // One-hot sequencer states
  localparam logic [ST_WDTH-1:0] IDLE  = 4'b0001;
  localparam logic [ST_WDTH-1:0] START = 4'b0010;
  localparam logic [ST_WDTH-1:0] WAIT  = 4'b0100;
  localparam logic [ST_WDTH-1:0] NEXT  = 4'b1000;

  localparam logic [31:0] DAC_AXI_BASE_ADDR = 32'h9000_0000;
  localparam logic [31:0] DAC_BLK_STRIDE    = 32'h1000_0000;
  localparam logic [31:0] DAC_TIMEOUT_CYC   = 32'd50_000_000;

endpackage

// File: rtl/cmip_edge_sync_sr.sv
// rtl/cmip_edge_sync_sr.sv - Two-flop synchroniser followed by a registered rising-edge pulse.
module cmip_edge_sync_sr (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_prev;
  logic r_rise;

  // The retiming stage after the synchroniser places the pulse three edges after first capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_prev   <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_prev   <= r_sync_q;
      r_rise   <= r_sync_q & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/dac_dma_rd_ring_ctrl.sv
// rtl/dac_dma_rd_ring_ctrl.sv - N-block ring DMA read sequencer for the DAC playback path.
// Optional WAIT-state watchdog is enabled by defining DAC_RD_TIMEOUT_EN.
module dac_dma_rd_ring_ctrl
  import dac_dma_pkg::*;
#(
  parameter int                   LEN_WDTH      = 32,
  parameter int                   ADDR_WDTH     = 32,
  parameter int                   BLK_NUM       = 4,
  parameter int                   BLK_IDX_WDTH  = $clog2(BLK_NUM),
  parameter logic [ADDR_WDTH-1:0] AXI_BASE_ADDR = ADDR_WDTH'(DAC_AXI_BASE_ADDR),
  parameter logic [ADDR_WDTH-1:0] BLK_STRIDE    = ADDR_WDTH'(DAC_BLK_STRIDE),
  parameter logic [31:0]          TIMEOUT_CYC   = DAC_TIMEOUT_CYC
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cfg_rs,
  input  logic                    cfg_mode,
  input  logic                    cfg_rst,
  input  logic [LEN_WDTH-1:0]     cfg_size,
  input  logic [BLK_IDX_WDTH:0]   cfg_blk_cnt,
  input  logic [LEN_WDTH-1:0]     cfg_loop_num,
  output logic [BLK_IDX_WDTH-1:0] sts_blk_idx,
  output logic [LEN_WDTH-1:0]     sts_rec_times,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    sts_timeout,
  output logic                    cfg_rsoft_rst,
  output logic                    cfg_rstart,
  output logic [ADDR_WDTH-1:0]    cfg_raddr,
  output logic [LEN_WDTH-1:0]     cfg_rlen,
  input  logic                    cfg_ridle
);

  localparam logic [BLK_IDX_WDTH:0] BLK_MAX = (BLK_IDX_WDTH+1)'(BLK_NUM);

  logic [ST_WDTH-1:0]      r_state;
  logic [ST_WDTH-1:0]      w_next;
  logic                    w_clr;
  logic                    w_run_trig;
  logic                    w_idle_rise;
  logic                    w_start_ok;
  logic                    w_more_blk;
  logic                    w_loop_again;
  logic                    w_wd_expire;
  logic                    w_to_pulse;
  logic                    w_timeout;
  logic                    w_rstart;
  logic                    w_busy;
  logic [BLK_IDX_WDTH:0]   w_blk_cnt_in;
  logic [LEN_WDTH-1:0]     w_rec_next;

  logic [BLK_IDX_WDTH-1:0] r_idx;
  logic [BLK_IDX_WDTH:0]   r_blk_cnt;
  logic [LEN_WDTH-1:0]     r_size;
  logic [LEN_WDTH-1:0]     r_loop_num;
  logic [LEN_WDTH-1:0]     r_rec_times;
  logic                    r_mode;
  logic                    r_done;
  logic [ADDR_WDTH-1:0]    r_raddr;

  assign w_clr = sys_rst | cfg_rst;

  cmip_edge_sync_sr u_rs_sync (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_async (cfg_rs),
    .o_rise  (w_run_trig)
  );

  cmip_edge_sync_sr u_ridle_sync (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_async (cfg_ridle),
    .o_rise  (w_idle_rise)
  );

  // A zero block count still plays one block; oversize counts wrap the whole ring
  always_comb begin
    w_blk_cnt_in = cfg_blk_cnt;
    if (cfg_blk_cnt == '0) begin
      w_blk_cnt_in = (BLK_IDX_WDTH+1)'(1);
    end else if (cfg_blk_cnt > BLK_MAX) begin
      w_blk_cnt_in = BLK_MAX;
    end
  end

  assign w_start_ok   = w_run_trig && (cfg_size != '0);
  assign w_more_blk   = ({1'b0, r_idx} + (BLK_IDX_WDTH+1)'(1)) < r_blk_cnt;
  assign w_rec_next   = (&r_rec_times) ? r_rec_times : r_rec_times + LEN_WDTH'(1);
  assign w_loop_again = r_mode && ((r_loop_num == '0) || (w_rec_next < r_loop_num));

`ifdef DAC_RD_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_to_pulse;
  logic        r_timeout;

  always_ff @(posedge sys_clk) begin
    if (w_clr || (r_state != WAIT)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  assign w_wd_expire = (r_state == WAIT) && !w_idle_rise && (r_wd_cnt == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_to_pulse <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_to_pulse <= w_wd_expire;
      if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_to_pulse = r_to_pulse;
  assign w_timeout  = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
  assign w_wd_expire          = 1'b0;
  assign w_to_pulse           = 1'b0;
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = START;
      START:   w_next = WAIT;
      WAIT: begin
        if (w_idle_rise) begin
          w_next = NEXT;
        end else if (w_wd_expire) begin
          w_next = IDLE;
        end
      end
      NEXT:    w_next = (w_more_blk || w_loop_again) ? START : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rstart = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      IDLE:    w_busy   = 1'b0;
      START:   w_rstart = 1'b1;
      default: ;
    endcase
  end

  // Address walks the ring by accumulating the stride, equal to base + idx*stride modulo the bus width
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_idx       <= '0;
      r_blk_cnt   <= '0;
      r_size      <= '0;
      r_loop_num  <= '0;
      r_rec_times <= '0;
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
      r_raddr     <= AXI_BASE_ADDR;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_size      <= cfg_size;
            r_blk_cnt   <= w_blk_cnt_in;
            r_loop_num  <= cfg_loop_num;
            r_mode      <= cfg_mode;
            r_rec_times <= '0;
            r_idx       <= '0;
            r_raddr     <= AXI_BASE_ADDR;
          end
        end
        NEXT: begin
          if (w_more_blk) begin
            r_idx   <= r_idx + BLK_IDX_WDTH'(1);
            r_raddr <= r_raddr + BLK_STRIDE;
          end else begin
            r_rec_times <= w_rec_next;
            if (w_loop_again) begin
              r_idx   <= '0;
              r_raddr <= AXI_BASE_ADDR;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sts_blk_idx   = r_idx;
  assign sts_rec_times = r_rec_times;
  assign sts_busy      = w_busy;
  assign sts_done      = r_done;
  assign sts_timeout   = w_timeout;
  assign cfg_rsoft_rst = cfg_rst | w_to_pulse;
  assign cfg_rstart    = w_rstart;
  assign cfg_raddr     = r_raddr;
  assign cfg_rlen      = r_size;

endmodule

// File: tb/tb_dac_dma_rd_ring_ctrl.sv
// tb/tb_dac_dma_rd_ring_ctrl.sv - Self-checking bench for the DAC DMA ring read sequencer.
module tb_dac_dma_rd_ring_ctrl;

  localparam logic [31:0] BASE   = 32'h9000_0000;
  localparam logic [31:0] STRIDE = 32'h1000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cfg_rs;
  logic        cfg_mode;
  logic        cfg_rst;
  logic [31:0] cfg_size;
  logic [2:0]  cfg_blk_cnt;
  logic [31:0] cfg_loop_num;
  logic [1:0]  sts_blk_idx;
  logic [31:0] sts_rec_times;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_timeout;
  logic        cfg_rsoft_rst;
  logic        cfg_rstart;
  logic [31:0] cfg_raddr;
  logic [31:0] cfg_rlen;
  logic        cfg_ridle;

  dac_dma_rd_ring_ctrl #(
    .LEN_WDTH    (32),
    .ADDR_WDTH   (32),
    .BLK_NUM     (4),
    .TIMEOUT_CYC (32'd100)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cfg_rs        (cfg_rs),
    .cfg_mode      (cfg_mode),
    .cfg_rst       (cfg_rst),
    .cfg_size      (cfg_size),
    .cfg_blk_cnt   (cfg_blk_cnt),
    .cfg_loop_num  (cfg_loop_num),
    .sts_blk_idx   (sts_blk_idx),
    .sts_rec_times (sts_rec_times),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_timeout   (sts_timeout),
    .cfg_rsoft_rst (cfg_rsoft_rst),
    .cfg_rstart    (cfg_rstart),
    .cfg_raddr     (cfg_raddr),
    .cfg_rlen      (cfg_rlen),
    .cfg_ridle     (cfg_ridle)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] size;
    logic [2:0]  blk;
    logic        mode;
    logic [31:0] loopn;
    bit          retrig;
    int          exp_starts;
    int          exp_done;
    logic [31:0] exp_rec;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_errs   = 0;
  int cap_starts;
  int cap_done;
  int cap_lat;
  int cap_busy_after;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_blk(input logic [2:0] b);
    if (b == 3'd0) return 1;
    if (b > 3'd4) return 4;
    return int'(b);
  endfunction

  function automatic logic [31:0] model_addr(input int i);
    logic [63:0] a;
    a = {32'h0, BASE} + 64'(i) * {32'h0, STRIDE};
    return a[31:0];
  endfunction

  // Drives one run and plays the DMA engine; stop_rec > 0 leaves the run parked in WAIT
  task automatic run_cfg(input logic [31:0] size, input logic [2:0] blk, input logic mode,
                         input logic [31:0] loopn, input int budget, input bit retrig,
                         input int stop_rec);
    int ack;
    int eff;
    int post;
    bit done_seen;
    eff = eff_blk(blk);
    cap_starts = 0; cap_done = 0; cap_lat = -1; cap_busy_after = 1;
    ack = 0; post = 0; done_seen = 0;
    cfg_size = size; cfg_blk_cnt = blk; cfg_mode = mode; cfg_loop_num = loopn;
    @(negedge sys_clk);
    cfg_rs = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge sys_clk);
      #1;
      if (cfg_rstart) begin
        if (cap_lat < 0) cap_lat = c - 1;
        chk("raddr", cfg_raddr, model_addr(cap_starts % eff));
        chk("blk_idx", sts_blk_idx, cap_starts % eff);
        chk("rlen", cfg_rlen, size);
        cap_starts++;
        if (stop_rec > 0 && sts_rec_times == stop_rec) break;
        cfg_ridle = 1'b0;
        ack = 2 + $urandom_range(0, 3);
      end else if (ack > 0) begin
        ack--;
        if (ack == 0) cfg_ridle = 1'b1;
      end
      if (c == 6) cfg_rs = 1'b0;
      if (c == 8) cfg_mode = ~cfg_mode;
      if (retrig && c == 16) cfg_rs = 1'b1;
      if (sts_done) begin
        cap_done++;
        cap_busy_after = sts_busy;
        done_seen = 1;
      end
      if (done_seen) begin
        post++;
        if (post > 20) break;
      end
    end
    cfg_rs = 1'b0;
    cfg_ridle = 1'b1;
    repeat (6) @(posedge sys_clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_rec;
    logic [31:0] m_last;
    sys_rst = 1'b1; cfg_rs = 1'b0; cfg_mode = 1'b0; cfg_rst = 1'b0;
    cfg_size = '0; cfg_blk_cnt = '0; cfg_loop_num = '0; cfg_ridle = 1'b1;

    vecs[0] = '{32'h0,    3'd2, 1'b0, 32'd0, 1'b0, 0,  0, 32'd0, 32'h9000_0000};
    vecs[1] = '{32'h1000, 3'd3, 1'b0, 32'd0, 1'b0, 3,  1, 32'd1, 32'hB000_0000};
    vecs[2] = '{32'h200,  3'd2, 1'b1, 32'd2, 1'b0, 4,  1, 32'd2, 32'hA000_0000};
    vecs[3] = '{32'h40,   3'd0, 1'b0, 32'd0, 1'b0, 1,  1, 32'd1, 32'h9000_0000};
    vecs[4] = '{32'h80,   3'd7, 1'b0, 32'd0, 1'b0, 4,  1, 32'd1, 32'hC000_0000};
    vecs[5] = '{32'h10,   3'd4, 1'b1, 32'd3, 1'b0, 12, 1, 32'd3, 32'hC000_0000};
    vecs[6] = '{32'h100,  3'd4, 1'b0, 32'd0, 1'b1, 4,  1, 32'd1, 32'hC000_0000};

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_busy", sts_busy, 0);
    chk("rst_done", sts_done, 0);
    chk("rst_rstart", cfg_rstart, 0);
    chk("rst_idx", sts_blk_idx, 0);
    chk("rst_rec", sts_rec_times, 0);
    chk("rst_raddr", cfg_raddr, BASE);
    chk("rst_rlen", cfg_rlen, 0);
    chk("rst_timeout", sts_timeout, 0);
    chk("rst_soft", cfg_rsoft_rst, 0);
    sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);

    for (int i = 0; i < 7; i++) begin
      run_cfg(vecs[i].size, vecs[i].blk, vecs[i].mode, vecs[i].loopn, 600, vecs[i].retrig, 0);
      chk($sformatf("v%0d_starts", i), cap_starts, vecs[i].exp_starts);
      chk($sformatf("v%0d_done", i), cap_done, vecs[i].exp_done);
      chk($sformatf("v%0d_rec", i), sts_rec_times, vecs[i].exp_rec);
      chk($sformatf("v%0d_last_addr", i), cfg_raddr, vecs[i].exp_last);
      chk($sformatf("v%0d_busy_idle", i), sts_busy, 0);
      if (vecs[i].exp_starts > 0) begin
        chk($sformatf("v%0d_latency", i), cap_lat, 4);
        chk($sformatf("v%0d_busy_at_done", i), cap_busy_after, 0);
      end
    end

    m_rec  = vecs[6].exp_rec;
    m_last = vecs[6].exp_last;
    for (int r = 0; r < 8; r++) begin
      logic [31:0] sz;
      logic [2:0]  bk;
      logic        md;
      logic [31:0] ln;
      int          passes;
      int          es;
      sz = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      bk = 3'($urandom_range(0, 7));
      md = 1'($urandom_range(0, 1));
      ln = 32'($urandom_range(1, 3));
      passes = md ? int'(ln) : 1;
      es = (sz == 0) ? 0 : eff_blk(bk) * passes;
      if (sz != 0) begin
        m_rec  = 32'(passes);
        m_last = model_addr(eff_blk(bk) - 1);
      end
      run_cfg(sz, bk, md, ln, 700, 1'b0, 0);
      chk($sformatf("r%0d_starts", r), cap_starts, es);
      chk($sformatf("r%0d_done", r), cap_done, (sz == 0) ? 0 : 1);
      chk($sformatf("r%0d_rec", r), sts_rec_times, m_rec);
      chk($sformatf("r%0d_last_addr", r), cfg_raddr, m_last);
    end

    run_cfg(32'h400, 3'd2, 1'b1, 32'd0, 2000, 1'b0, 5);
    chk("inf_rec_before_abort", sts_rec_times, 5);
    chk("inf_busy_before_abort", sts_busy, 1);
    chk("inf_no_done", cap_done, 0);
    @(negedge sys_clk);
    cfg_rst = 1'b1;
    #1;
    chk("abort_soft_rst", cfg_rsoft_rst, 1);
    @(posedge sys_clk);
    #1;
    chk("abort_busy", sts_busy, 0);
    chk("abort_rec", sts_rec_times, 0);
    chk("abort_raddr", cfg_raddr, BASE);
    chk("abort_rlen", cfg_rlen, 0);
    chk("abort_idx", sts_blk_idx, 0);
    @(negedge sys_clk);
    cfg_rst = 1'b0;
    #1;
    chk("abort_soft_rst_low", cfg_rsoft_rst, 0);
    begin
      int nd;
      int ns;
      nd = 0; ns = 0;
      repeat (30) begin
        @(posedge sys_clk);
        #1;
        if (sts_done) nd++;
        if (cfg_rstart) ns++;
      end
      chk("abort_no_done", nd, 0);
      chk("abort_no_start", ns, 0);
    end

`ifdef DAC_RD_TIMEOUT_EN
    begin
      int w;
      int dn;
      w = 0; dn = 0;
      cfg_size = 32'h10; cfg_blk_cnt = 3'd1; cfg_mode = 1'b0;
      @(negedge sys_clk);
      cfg_rs = 1'b1;
      while (!cfg_rstart && w < 20) begin
        @(posedge sys_clk);
        #1;
        w++;
      end
      chk("to_start_seen", cfg_rstart, 1);
      for (int k = 1; k <= 102; k++) begin
        @(posedge sys_clk);
        #1;
        if (sts_done) dn++;
        if (k == 100) begin
          chk("to_busy_before", sts_busy, 1);
          chk("to_flag_before", sts_timeout, 0);
        end
        if (k == 101) begin
          chk("to_busy_after", sts_busy, 0);
          chk("to_flag_set", sts_timeout, 1);
          chk("to_soft_pulse", cfg_rsoft_rst, 1);
        end
        if (k == 102) begin
          chk("to_soft_pulse_end", cfg_rsoft_rst, 0);
          chk("to_flag_sticky", sts_timeout, 1);
        end
      end
      chk("to_no_done", dn, 0);
      cfg_rs = 1'b0;
      @(negedge sys_clk);
      cfg_rst = 1'b1;
      @(negedge sys_clk);
      cfg_rst = 1'b0;
      #1;
      chk("to_flag_cleared", sts_timeout, 0);
    end
`else
    chk("timeout_tied_low", sts_timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
